// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter.
// The optional parity stage is enabled by defining FIFO_UART_TX_PARITY_EN.
package fifo_uart_tx_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

   localparam logic TX_IDLE_LEVEL = 1'b1;

   // Width of a counter that has to reach n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fifo_uart_tx_baud.sv
// Bit-period counter: flags the final clk cycle of every serial bit.
// Held at zero while clear is high so a new frame always starts on a full bit.
module baud_tick_counter
   import fifo_uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic last_tick
);

   localparam int CW = cnt_width(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST_COUNT = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] count;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear || last_tick) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   assign last_tick = !clear && (count == LAST_COUNT);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a show-ahead FIFO and sends them as start/8N/stop serial frames.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between DATA and STOP.
module fifo_uart_tx
   import fifo_uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_W       = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tx_en,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              fifo_read_en,
   output logic              tx,
   output logic              busy,
   output logic              frame_done
);

   localparam int BW = cnt_width(DATA_W);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

   tx_state_t         state, state_next;
   logic [DATA_W-1:0] shift, shift_next;
   logic [BW-1:0]     bit_idx, bit_idx_next;
   logic              tx_next;
   logic              last_tick;
   logic              pop;
`ifdef FIFO_UART_TX_PARITY_EN
   logic              parity;
`endif

   baud_tick_counter #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk       (clk),
      .rst       (rst),
      .clear     (state == IDLE),
      .last_tick (last_tick)
   );

   // Pop points: idle, or the final STOP cycle so frames can run back to back.
   assign pop = !rst && tx_en && !fifo_empty &&
                ((state == IDLE) || ((state == STOP) && last_tick));

   assign fifo_read_en = pop;
   assign busy         = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         shift      <= '0;
         bit_idx    <= '0;
         tx         <= TX_IDLE_LEVEL;
         frame_done <= 1'b0;
      end else begin
         state      <= state_next;
         shift      <= shift_next;
         bit_idx    <= bit_idx_next;
         tx         <= tx_next;
         frame_done <= (state == STOP) && last_tick;
      end
   end

`ifdef FIFO_UART_TX_PARITY_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         parity <= 1'b0;
      end else if (pop) begin
         parity <= ^fifo_data;
      end
   end
`endif

   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      state_next = state;
      case (state)
         IDLE:    if (pop) state_next = START;
         START:   if (last_tick) state_next = DATA;
         DATA: begin
            if (last_tick && (bit_idx == LAST_BIT)) begin
`ifdef FIFO_UART_TX_PARITY_EN
               state_next = PARITY;
`else
               state_next = STOP;
`endif
            end
         end
`ifdef FIFO_UART_TX_PARITY_EN
         PARITY:  if (last_tick) state_next = STOP;
`endif
         STOP:    if (last_tick) state_next = pop ? START : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // tx is derived from the next state so the registered line changes on bit boundaries.
   always_comb begin
      shift_next   = shift;
      bit_idx_next = bit_idx;
      tx_next      = TX_IDLE_LEVEL;

      if (pop) begin
         shift_next   = fifo_data;
         bit_idx_next = '0;
      end else if ((state == DATA) && last_tick) begin
         shift_next   = shift >> 1;
         bit_idx_next = (bit_idx == LAST_BIT) ? '0 : bit_idx + 1'b1;
      end

      case (state_next)
         START:   tx_next = 1'b0;
         DATA:    tx_next = shift_next[0];
`ifdef FIFO_UART_TX_PARITY_EN
         PARITY:  tx_next = parity;
`endif
         default: tx_next = TX_IDLE_LEVEL;
      endcase
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx with a show-ahead FIFO model and a per-cycle frame model.
// Define FIFO_UART_TX_PARITY_EN to exercise the parity build.
module tb_fifo_uart_tx;

   localparam int C = 4;
   localparam int W = 8;
`ifdef FIFO_UART_TX_PARITY_EN
   localparam int NBITS = W + 3;
`else
   localparam int NBITS = W + 2;
`endif
   localparam int FRAME = NBITS * C;

   logic         clk;
   logic         rst;
   logic         tx_en;
   logic         fifo_empty;
   logic [W-1:0] fifo_data;
   logic         fifo_read_en;
   logic         tx;
   logic         busy;
   logic         frame_done;

   fifo_uart_tx #(
      .CLKS_PER_BIT(C),
      .DATA_W      (W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .tx_en        (tx_en),
      .fifo_empty   (fifo_empty),
      .fifo_data    (fifo_data),
      .fifo_read_en (fifo_read_en),
      .tx           (tx),
      .busy         (busy),
      .frame_done   (frame_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks;
   int n_errors;
   int cyc;

   // Show-ahead FIFO contents (depth 4).
   logic [W-1:0] fq[$];

   // Frame model: position within the current frame in clk cycles, -1 when idle.
   int           m_pos;
   logic [W-1:0] m_cur;
   logic         m_done;

   // Observations from the most recent cycle and running statistics.
   logic s_tx;
   logic s_busy;
   int   pop_count;
   int   last_pop;
   int   last_fd;
   int   busy_low;

   function automatic logic m_level();
      int b;
      if (m_pos < 0) return 1'b1;
      b = m_pos / C;
      if (b == 0) return 1'b0;
      if (b <= W) return m_cur[b-1];
      if ((NBITS == W + 3) && (b == W + 1)) return ^m_cur;
      return 1'b1;
   endfunction

   task automatic refresh_fifo();
      fifo_empty = (fq.size() == 0);
      fifo_data  = (fq.size() != 0) ? fq[0] : '0;
   endtask

   task automatic push(input logic [W-1:0] b);
      if (fq.size() < 4) fq.push_back(b);
      refresh_fifo();
   endtask

   // One clk cycle: sample at the falling edge, advance the model at the rising edge,
   // then let the FIFO react to the pop shortly after the edge.
   task automatic step();
      logic exp_tx;
      logic exp_busy;
      logic exp_rd;
      logic pop_now;
      @(negedge clk);
      exp_tx   = m_level();
      exp_busy = (m_pos >= 0);
      exp_rd   = !rst && tx_en && (fq.size() != 0) && ((m_pos < 0) || (m_pos == FRAME - 1));

      n_checks++;
      if (tx !== exp_tx) begin
         n_errors++;
         $display("FAIL tx cyc=%0d got=%b exp=%b", cyc, tx, exp_tx);
      end
      n_checks++;
      if (busy !== exp_busy) begin
         n_errors++;
         $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy);
      end
      n_checks++;
      if (frame_done !== m_done) begin
         n_errors++;
         $display("FAIL frame_done cyc=%0d got=%b exp=%b", cyc, frame_done, m_done);
      end
      n_checks++;
      if (fifo_read_en !== exp_rd) begin
         n_errors++;
         $display("FAIL fifo_read_en cyc=%0d got=%b exp=%b", cyc, fifo_read_en, exp_rd);
      end

      s_tx   = tx;
      s_busy = busy;
      if (fifo_read_en === 1'b1) begin
         pop_count++;
         last_pop = cyc;
      end
      if (frame_done === 1'b1) last_fd = cyc;
      if (busy !== 1'b1) busy_low++;
      pop_now = (fifo_read_en === 1'b1);

      @(posedge clk);
      if (rst) begin
         m_pos  = -1;
         m_done = 1'b0;
      end else begin
         m_done = (m_pos == FRAME - 1);
         if (exp_rd) begin
            m_cur = fq[0];
            m_pos = 0;
         end else if (m_pos >= 0) begin
            m_pos = (m_pos == FRAME - 1) ? -1 : m_pos + 1;
         end
      end
      #1;
      if (pop_now && (fq.size() != 0)) void'(fq.pop_front());
      refresh_fifo();
      cyc++;
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic wait_pop(input int limit, input string name);
      int pc0;
      int k;
      pc0 = pop_count;
      k   = 0;
      while ((pop_count == pc0) && (k < limit)) begin
         step();
         k++;
      end
      n_checks++;
      if (pop_count == pc0) begin
         n_errors++;
         $display("FAIL %s: no fifo_read_en within %0d cycles", name, limit);
      end
   endtask

   task automatic test_reset();
      int pc0;
      #3;
      n_checks++;
      if ({tx, busy, fifo_read_en, frame_done} !== 4'b1000) begin
         n_errors++;
         $display("FAIL reset_hold got tx/busy/rd/fd=%b exp=1000", {tx, busy, fifo_read_en, frame_done});
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      wait_pop(4, "reset_first_pop");
      run(14);
      // Assert reset in the middle of the frame; outputs must return at once.
      rst = 1'b1;
      #1;
      n_checks++;
      if ({tx, busy, fifo_read_en} !== 3'b100) begin
         n_errors++;
         $display("FAIL reset_midframe got tx/busy/rd=%b exp=100", {tx, busy, fifo_read_en});
      end
      m_pos  = -1;
      m_done = 1'b0;
      run(2);
      rst = 1'b0;
      pc0 = pop_count;
      run(10);
      n_checks++;
      if (pop_count != pc0) begin
         n_errors++;
         $display("FAIL reset_no_resend got pops=%0d exp=0", pop_count - pc0);
      end
      push(8'h12);
      wait_pop(4, "reset_pop_after_push");
      run(FRAME + 2);
   endtask

   task automatic test_single();
      logic [9:0] seq;
      int p;
      int pc0;
      int k;
`ifdef FIFO_UART_TX_PARITY_EN
      seq = 10'b01_0100_1010;
`else
      seq = 10'b11_0100_1010;
`endif
      pc0 = pop_count;
      push(8'hA5);
      wait_pop(4, "single_pop");
      p = last_pop;
      for (int b = 0; b < 10; b++) begin
         step();
         step();
         n_checks++;
         if (s_tx !== seq[b]) begin
            n_errors++;
            $display("FAIL single_bit%0d got=%b exp=%b", b, s_tx, seq[b]);
         end
         step();
         step();
      end
      k = 0;
      while ((last_fd <= p) && (k < 20)) begin
         step();
         k++;
      end
      // frame_done is seen in cycle p+FRAME+1, i.e. FRAME edges after the pop edge.
      n_checks++;
      if (last_fd - p != FRAME + 1) begin
         n_errors++;
         $display("FAIL single_frame_done got=%0d exp=%0d", last_fd - p, FRAME + 1);
      end
      n_checks++;
      if (pop_count - pc0 != 1) begin
         n_errors++;
         $display("FAIL single_pop_count got=%0d exp=1", pop_count - pc0);
      end
      run(3);
   endtask

   task automatic test_back_to_back();
      int p1;
      int p2;
      int bl0;
      push(8'h00);
      push(8'hFF);
      wait_pop(4, "b2b_first_pop");
      p1  = last_pop;
      bl0 = busy_low;
      wait_pop(FRAME + 4, "b2b_second_pop");
      p2 = last_pop;
      n_checks++;
      if (p2 - p1 != FRAME) begin
         n_errors++;
         $display("FAIL b2b_pop_spacing got=%0d exp=%0d", p2 - p1, FRAME);
      end
      step();
      n_checks++;
      if ({s_tx, s_busy} !== 2'b01) begin
         n_errors++;
         $display("FAIL b2b_start_follows got tx/busy=%b exp=01", {s_tx, s_busy});
      end
      n_checks++;
      if (busy_low != bl0) begin
         n_errors++;
         $display("FAIL b2b_busy_gap got=%0d exp=0", busy_low - bl0);
      end
      run(FRAME + 3);
   endtask

   task automatic test_tx_en_drop();
      int p;
      int pc0;
      push(8'h3C);
      push(8'h55);
      wait_pop(4, "drop_first_pop");
      p = last_pop;
      run(10);
      tx_en = 1'b0;
      pc0 = pop_count;
      run(FRAME + 20);
      n_checks++;
      if (pop_count != pc0) begin
         n_errors++;
         $display("FAIL drop_no_pop got=%0d exp=0", pop_count - pc0);
      end
      n_checks++;
      if (last_fd - p != FRAME + 1) begin
         n_errors++;
         $display("FAIL drop_frame_completes got=%0d exp=%0d", last_fd - p, FRAME + 1);
      end
      n_checks++;
      if ((fq.size() != 1) || (fifo_data !== 8'h55)) begin
         n_errors++;
         $display("FAIL drop_fifo_kept got size=%0d head=%h exp size=1 head=55", fq.size(), fifo_data);
      end
      tx_en = 1'b1;
      wait_pop(3, "drop_resume_pop");
      run(FRAME + 2);
   endtask

   task automatic test_empty();
      int pc0;
      int low;
      pc0 = pop_count;
      low = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (s_tx !== 1'b1) low++;
      end
      n_checks++;
      if (pop_count != pc0) begin
         n_errors++;
         $display("FAIL empty_no_pop got=%0d exp=0", pop_count - pc0);
      end
      n_checks++;
      if (low != 0) begin
         n_errors++;
         $display("FAIL empty_tx_idle got low_cycles=%0d exp=0", low);
      end
   endtask

`ifdef FIFO_UART_TX_PARITY_EN
   task automatic test_parity();
      int p;
      int k;
      push(8'h07);
      wait_pop(4, "parity_pop");
      p = last_pop;
      run(9 * C + 2);
      n_checks++;
      if (s_tx !== 1'b1) begin
         n_errors++;
         $display("FAIL parity_bit got=%b exp=1", s_tx);
      end
      k = 0;
      while ((last_fd <= p) && (k < 20)) begin
         step();
         k++;
      end
      n_checks++;
      if (last_fd - p != 11 * C + 1) begin
         n_errors++;
         $display("FAIL parity_frame_len got=%0d exp=%0d", last_fd - p, 11 * C + 1);
      end
      run(3);
   endtask
`endif

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         if (($urandom_range(0, 5) == 0) && (fq.size() < 4)) push(W'($urandom));
         tx_en = ($urandom_range(0, 7) != 0);
         step();
      end
      tx_en = 1'b1;
      run(FRAME * 5 + 4);
      n_checks++;
      if ((fq.size() != 0) || (busy !== 1'b0)) begin
         n_errors++;
         $display("FAIL random_drain got size=%0d busy=%b exp size=0 busy=0", fq.size(), busy);
      end
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      cyc       = 0;
      pop_count = 0;
      last_pop  = -1;
      last_fd   = -1;
      busy_low  = 0;
      s_tx      = 1'b1;
      s_busy    = 1'b0;
      m_pos     = -1;
      m_cur     = '0;
      m_done    = 1'b0;
      rst       = 1'b1;
      tx_en     = 1'b1;
      push(8'h99);

      test_reset();
      test_single();
      test_back_to_back();
      test_tx_en_drop();
      test_empty();
`ifdef FIFO_UART_TX_PARITY_EN
      test_parity();
`endif
      test_random();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
